// File: rtl/polar_encoder.sv
// Iterative polar encoder: x = u * F^{(x)LOG2N} over GF(2), natural bit order.
// One butterfly stage is applied per clock; a single message is in flight at a time.
module polar_encoder #(
    parameter int             N           = 8,
    parameter int             LOG2N       = 3,
    parameter logic [N-1:0]   FROZEN_MASK = 8'h17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_bits,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_bits,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int STG_W = $clog2(LOG2N + 1);

    typedef enum logic [1:0] {
        IDLE,
        ENCODE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     v_q, v_d;
    logic [STG_W-1:0] stage_q, stage_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            v_q     <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            stage_q <= stage_d;
        end
    end

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        stage_d = stage_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    v_d     = in_bits & ~FROZEN_MASK;
                    stage_d = '0;
                    state_d = ENCODE;
                end
            end
            ENCODE: begin
                // Partner i|2^s equals i+2^s whenever bit s of i is clear, and stays in range.
                for (int unsigned s = 0; s < LOG2N; s++) begin
                    if (stage_q == STG_W'(s)) begin
                        for (int unsigned i = 0; i < N; i++) begin
                            if (((i >> s) & 1) == 0) begin
                                v_d[i] = v_q[i] ^ v_q[i | (32'd1 << s)];
                            end
                        end
                    end
                end
                if (stage_q == STG_W'(LOG2N - 1)) begin
                    state_d = DONE;
                end else begin
                    stage_d = stage_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_bits  = v_q;

endmodule
